// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - store/load/memory signal bundle for the data memory port arbiter
interface dmem_port_arbiter_if #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
);
    logic                     st_valid;
    logic                     st_ready;
    logic [WIDTH:0]           st_addr;
    logic [WIDTH:0]           st_data;
    logic [3:0]               st_bytEnable;
    logic                     ld_valid;
    logic                     ld_ready;
    logic [WIDTH:0]           ld_addr;
    logic                     ld_rvalid;
    logic [WIDTH:0]           ld_rdata;
    logic                     mem_en;
    logic                     mem_we;
    logic [WIDTH:0]           mem_addr;
    logic [WIDTH:0]           mem_wdata;
    logic [3:0]               mem_bytEnable;
    logic [WIDTH:0]           mem_rdata;
    logic [$clog2(DEPTH):0]   sq_count;

    modport slave (
        input  st_valid, st_addr, st_data, st_bytEnable, ld_valid, ld_addr, mem_rdata,
        output st_ready, ld_ready, ld_rvalid, ld_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, mem_bytEnable, sq_count
    );

    modport master (
        output st_valid, st_addr, st_data, st_bytEnable, ld_valid, ld_addr, mem_rdata,
        input  st_ready, ld_ready, ld_rvalid, ld_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, mem_bytEnable, sq_count
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - single data memory port shared by loads and a committed-store FIFO
// Loads win the port unless they hit a live or incoming store word, or the queue is full.
module dmem_port_arbiter #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    dmem_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH:0] addr_q [DEPTH];
    logic [WIDTH:0] data_q [DEPTH];
    logic [3:0]     be_q   [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           rvalid_q, rvalid_d;
    logic           full, accept, hit, grant_ld, grant_st;
    logic [PW-1:0]  off;

    always_comb begin
        full   = (count_q == FULL_CNT);
        accept = bus.st_valid && !full;
        hit    = bus.ld_valid && accept && (bus.st_addr[WIDTH:2] == bus.ld_addr[WIDTH:2]);
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // a slot is live when its distance from head is below the occupancy
            off = PW'(i) - head_q;
            if (bus.ld_valid && ({1'b0, off} < count_q) &&
                (addr_q[i][WIDTH:2] == bus.ld_addr[WIDTH:2]))
                hit = 1'b1;
        end
        grant_ld = bus.ld_valid && !hit && !full;
        grant_st = !grant_ld && (count_q != '0);
        head_d   = head_q + PW'(grant_st);
        tail_d   = tail_q + PW'(accept);
        count_d  = count_q + CW'(accept) - CW'(grant_st);
        rvalid_d = grant_ld;
    end

    always_comb begin
        bus.mem_en        = grant_ld || grant_st;
        bus.mem_we        = grant_st;
        bus.mem_addr      = bus.ld_addr;
        bus.mem_wdata     = data_q[head_q];
        bus.mem_bytEnable = 4'b0000;
        if (grant_st) begin
            bus.mem_addr      = addr_q[head_q];
            bus.mem_bytEnable = be_q[head_q];
        end
    end

    assign bus.st_ready  = !full;
    assign bus.ld_ready  = grant_ld;
    assign bus.ld_rvalid = rvalid_q;
    assign bus.ld_rdata  = bus.mem_rdata;
    assign bus.sq_count  = count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
        end
    end

    // entry storage needs no reset: occupancy alone decides which slots are live
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[tail_q] <= bus.st_addr;
            data_q[tail_q] <= bus.st_data;
            be_q[tail_q]   <= bus.st_bytEnable;
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
    logic clk;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_port_arbiter_if #(.WIDTH(31), .DEPTH(4)) bus ();

    dmem_port_arbiter #(.WIDTH(31), .DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: never-written words read as DEADBEEF
    logic [31:0] ram [int unsigned];
    logic [31:0] wl_addr [$];
    logic [31:0] wl_data [$];
    logic [3:0]  wl_be   [$];
    int unsigned k;
    logic [31:0] cur;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            k   = 32'(bus.mem_addr[11:2]);
            cur = ram.exists(k) ? ram[k] : 32'hDEADBEEF;
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_bytEnable[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                ram[k] = cur;
                wl_addr.push_back(bus.mem_addr);
                wl_data.push_back(bus.mem_wdata);
                wl_be.push_back(bus.mem_bytEnable);
            end else begin
                bus.mem_rdata <= cur;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.st_valid     = v;
        bus.st_addr      = a;
        bus.st_data      = d;
        bus.st_bytEnable = be;
    endtask

    task automatic drive_ld(input logic v, input logic [31:0] a);
        bus.ld_valid = v;
        bus.ld_addr  = a;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (bus.sq_count != 0 && n < 20) begin
            step();
            settle();
            n++;
        end
        check(tag, 64'(bus.sq_count), 64'd0);
    endtask

    int base;

    initial begin
        resetn = 1'b0;
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        drive_ld(1'b0, 32'h0);
        repeat (2) step();
        check("rst_count", 64'(bus.sq_count), 64'd0);
        check("rst_mem_en", 64'(bus.mem_en), 64'd0);
        check("rst_rvalid", 64'(bus.ld_rvalid), 64'd0);
        resetn = 1'b1;
        settle();
        check("rst_st_ready", 64'(bus.st_ready), 64'd1);

        // idle-queue load
        step();
        drive_ld(1'b1, 32'h100);
        settle();
        check("ld_ready", 64'(bus.ld_ready), 64'd1);
        check("ld_mem_en", 64'(bus.mem_en), 64'd1);
        check("ld_mem_we", 64'(bus.mem_we), 64'd0);
        check("ld_mem_addr", 64'(bus.mem_addr), 64'h100);
        check("ld_be", 64'(bus.mem_bytEnable), 64'd0);
        step();
        drive_ld(1'b0, 32'h0);
        settle();
        check("ld_rvalid", 64'(bus.ld_rvalid), 64'd1);
        check("ld_rdata", 64'(bus.ld_rdata), 64'hDEADBEEF);
        step();
        settle();
        check("ld_rvalid_drop", 64'(bus.ld_rvalid), 64'd0);

        // drain order: loads to 0x300 hold the port while three stores queue up
        base = wl_addr.size();
        drive_ld(1'b1, 32'h300);
        drive_st(1'b1, 32'h10, 32'h000000A1, 4'b0001);
        settle();
        check("fill_ld_ready", 64'(bus.ld_ready), 64'd1);
        step();
        drive_st(1'b1, 32'h14, 32'h0000B2B2, 4'b0011);
        step();
        drive_st(1'b1, 32'h18, 32'hC3C3C3C3, 4'b1111);
        step();
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        drive_ld(1'b0, 32'h0);
        settle();
        check("drain_cnt3", 64'(bus.sq_count), 64'd3);
        check("drain0_we", 64'(bus.mem_we), 64'd1);
        check("drain0_addr", 64'(bus.mem_addr), 64'h10);
        check("drain0_be", 64'(bus.mem_bytEnable), 64'b0001);
        step();
        settle();
        check("drain_cnt2", 64'(bus.sq_count), 64'd2);
        check("drain1_addr", 64'(bus.mem_addr), 64'h14);
        step();
        settle();
        check("drain_cnt1", 64'(bus.sq_count), 64'd1);
        check("drain2_addr", 64'(bus.mem_addr), 64'h18);
        step();
        settle();
        check("drain_cnt0", 64'(bus.sq_count), 64'd0);
        check("drain_idle", 64'(bus.mem_en), 64'd0);
        check("drain_nwr", 64'(wl_addr.size() - base), 64'd3);
        check("wr0", {wl_addr[base], wl_data[base], 28'd0, wl_be[base]} >> 32, {32'h10, 32'h000000A1});
        check("wr1_data", 64'(wl_data[base+1]), 64'h0000B2B2);
        check("wr1_be", 64'(wl_be[base+1]), 64'b0011);
        check("wr2_data", 64'(wl_data[base+2]), 64'hC3C3C3C3);
        check("wr2_be", 64'(wl_be[base+2]), 64'b1111);

        // hazard against a queued store in the same word
        drive_st(1'b1, 32'h22, 32'h00AB0000, 4'b0100);
        step();
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        drive_ld(1'b1, 32'h20);
        settle();
        check("haz_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("haz_drain_we", 64'(bus.mem_we), 64'd1);
        check("haz_drain_addr", 64'(bus.mem_addr), 64'h22);
        check("haz_drain_be", 64'(bus.mem_bytEnable), 64'b0100);
        step();
        settle();
        check("haz_ld_grant", 64'(bus.ld_ready), 64'd1);
        check("haz_ld_addr", 64'(bus.mem_addr), 64'h20);
        step();
        drive_ld(1'b0, 32'h0);
        settle();
        check("haz_rvalid", 64'(bus.ld_rvalid), 64'd1);
        check("haz_rdata", 64'(bus.ld_rdata), 64'hDEABBEEF);

        // hazard against a store being accepted in the same cycle
        drive_st(1'b1, 32'h503, 32'h77000000, 4'b1000);
        drive_ld(1'b1, 32'h500);
        settle();
        check("inc_haz_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("inc_haz_mem_en", 64'(bus.mem_en), 64'd0);
        step();
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check("inc_haz_drain", 64'(bus.mem_addr), 64'h503);
        check("inc_haz_ld_wait", 64'(bus.ld_ready), 64'd0);
        step();
        settle();
        check("inc_haz_ld_grant", 64'(bus.ld_ready), 64'd1);
        step();
        drive_ld(1'b0, 32'h0);

        // full queue forces drain ahead of an unrelated load
        drive_ld(1'b1, 32'h400);
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 32'h40 + 32'(4*i), 32'h11111111 * 32'(i+1), 4'hF);
            step();
        end
        drive_st(1'b1, 32'h50, 32'h55555555, 4'hF);
        settle();
        check("full_cnt", 64'(bus.sq_count), 64'd4);
        check("full_st_ready", 64'(bus.st_ready), 64'd0);
        check("full_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("full_drain_addr", 64'(bus.mem_addr), 64'h40);
        step();
        settle();
        check("full_cnt3", 64'(bus.sq_count), 64'd3);
        check("full_accept5", 64'(bus.st_ready), 64'd1);
        check("full_ld_grant", 64'(bus.ld_ready), 64'd1);
        step();
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check("full_cnt4_again", 64'(bus.sq_count), 64'd4);
        check("full_drain2_addr", 64'(bus.mem_addr), 64'h44);
        step();
        drive_ld(1'b0, 32'h0);
        settle();
        wait_empty("full_empty");

        // steady enqueue+drain at occupancy 2 across pointer wrap
        base = wl_addr.size();
        drive_ld(1'b1, 32'h600);
        for (int i = 0; i < 2; i++) begin
            drive_st(1'b1, 32'h700 + 32'(4*i), 32'h5A000000 | 32'(i), 4'hF);
            step();
        end
        drive_ld(1'b0, 32'h0);
        for (int i = 2; i < 8; i++) begin
            drive_st(1'b1, 32'h700 + 32'(4*i), 32'h5A000000 | 32'(i), 4'hF);
            settle();
            check($sformatf("sim_cnt_%0d", i), 64'(bus.sq_count), 64'd2);
            check($sformatf("sim_wr_addr_%0d", i), 64'(bus.mem_addr), 64'h700 + 64'(4*(i-2)));
            step();
        end
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check("sim_cnt_after", 64'(bus.sq_count), 64'd2);
        wait_empty("sim_empty");
        check("sim_nwr", 64'(wl_addr.size() - base), 64'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("sim_order_%0d", i), 64'(wl_data[base+i]), 64'h5A000000 | 64'(i));

        // asynchronous reset mid-stream
        drive_ld(1'b1, 32'h800);
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, 32'h900 + 32'(4*i), 32'hEEEE0000 | 32'(i), 4'hF);
            step();
        end
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        drive_ld(1'b0, 32'h0);
        settle();
        check("pre_rst_cnt", 64'(bus.sq_count), 64'd3);
        check("pre_rst_rvalid", 64'(bus.ld_rvalid), 64'd1);
        base = wl_addr.size();
        resetn = 1'b0;
        #1;
        check("mid_rst_cnt", 64'(bus.sq_count), 64'd0);
        check("mid_rst_mem_en", 64'(bus.mem_en), 64'd0);
        check("mid_rst_rvalid", 64'(bus.ld_rvalid), 64'd0);
        step();
        resetn = 1'b1;
        settle();
        check("post_rst_st_ready", 64'(bus.st_ready), 64'd1);
        repeat (4) step();
        check("post_rst_nwr", 64'(wl_addr.size() - base), 64'd0);
        check("post_rst_cnt", 64'(bus.sq_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port, byte-enabled data memory between the load unit and committed stores.
- Committed stores arrive already lane-aligned, with their byte-enables generated upstream. They are held in a DEPTH-entry FIFO store queue and drained one per cycle when the port is free.
- Loads get the port first, unless they would read stale data or the queue is full.
- The block sits between the commit/load-store units and the data RAM.

Parameters:
- WIDTH, 31: MSB index of address/data buses (buses are WIDTH+1 bits).
- DEPTH, 4: store queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- st_valid  in  1  committed store offered
- st_ready  out  1  store accepted this cycle
- st_addr  in  WIDTH+1  store byte address
- st_data  in  WIDTH+1  lane-aligned store data
- st_bytEnable  in  4  byte lanes to write
- ld_valid  in  1  load request
- ld_ready  out  1  load granted the memory port this cycle
- ld_addr  in  WIDTH+1  load byte address
- ld_rvalid  out  1  load data valid, one cycle after grant
- ld_rdata  out  WIDTH+1  load data, full word
- mem_en  out  1  memory access this cycle
- mem_we  out  1  1 = write (store drain), 0 = read
- mem_addr  out  WIDTH+1  memory byte address
- mem_wdata  out  WIDTH+1  write data
- mem_bytEnable  out  4  write lane enables; 4'b0000 on reads
- mem_rdata  in  WIDTH+1  read data, valid the cycle after a read
- sq_count  out  $clog2(DEPTH)+1  current store queue occupancy

Behaviour:
- Reset (resetn low, asynchronous):
  - queue empty; head/tail pointers and sq_count = 0; ld_rvalid = 0.
  - Combinational outputs take their idle values: mem_en = 0, mem_we = 0, ld_ready = 0, mem_bytEnable = 0; st_ready = 1 once resetn is high.
  - A load granted in the cycle before reset asserts gets no ld_rvalid.
- Enqueue:
  - st_ready = (sq_count != DEPTH).
  - st_valid & st_ready writes the entry at tail; tail increments modulo DEPTH.
  - A new entry can drain the cycle after enqueue at the earliest; there is no same-cycle bypass.
- Hazard: hit = ld_valid and the word address (addr[WIDTH:2]) matches either any valid queue entry, or an incoming store being accepted this cycle.
- Arbitration, evaluated combinationally each cycle:
  - grant_ld = ld_valid & !hit & (sq_count != DEPTH).
  - grant_st = !grant_ld & (sq_count != 0).
  - A full queue forces store drain, so loads cannot starve stores. A hazard forces drain until the conflicting entries retire.
- Load grant:
  - ld_ready = 1, mem_en = 1, mem_we = 0, mem_addr = ld_addr, mem_bytEnable = 4'b0000.
  - Next cycle: ld_rvalid = 1 and ld_rdata = mem_rdata (combinational pass-through).
  - ld_rvalid is a register; ld_rdata is don't-care while ld_rvalid = 0.
- Store grant:
  - mem_en = 1, mem_we = 1; mem_addr/mem_wdata/mem_bytEnable come from the head entry.
  - The head pops at the clock edge; head increments modulo DEPTH.
- Neither granted: mem_en = 0, mem_we = 0, mem_bytEnable = 0; address/data outputs are don't-care.
- sq_count:
  - Enqueue and drain in the same cycle: sq_count unchanged.
  - Full queue: a drain and an enqueue cannot both happen in one cycle, because st_ready is 0. The accept happens the cycle after the drain.
- Ordering: stores retire in FIFO order. A load never reads a word with a pending older store, because it waits until that store has been written.
- Pointer wrap-around: head/tail are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from sq_count.

Test Plan:
- Reset mid-stream: fill 3 stores, pull resetn low asynchronously between edges → sq_count = 0, mem_en = 0, ld_rvalid = 0 immediately. After release, st_ready = 1 and no stale store is written.
- Idle-queue load: ld_valid with ld_addr = 0x100, queue empty → ld_ready = 1, mem_en = 1, mem_we = 0 that cycle. Next cycle ld_rvalid = 1 and ld_rdata equals mem_rdata (0xDEADBEEF).
- Drain and order: enqueue stores to 0x10/0x14/0x18 with bytEnable 0001/0011/1111, no loads → three consecutive writes in that order with matching wdata/bytEnable; sq_count goes 3, 2, 1, 0.
- Hazard stall: queue holds a store to 0x22 (bytEnable 0100), load to 0x20 → ld_ready = 0 and the store drains. The load is granted the following cycle and reads the updated word.
- Full-queue priority: fill all 4 entries, then hold ld_valid to an unrelated 0x400 → st_ready = 0, one store drains, then the load is granted. A fifth store is accepted only after sq_count < 4.
- Simultaneous enqueue/drain: sq_count = 2, present st_valid with no load → one write occurs and one store is accepted; sq_count stays 2. Tail wraps from index 3 to 0 correctly across 6 sequential stores.
